operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
Decode/operand-fetch stage directly upstream of the execute stage's operand-0 units and 8:1 result mux. It owns an 8×12 register file with one write-back port. It decodes a 12-bit instruction and reads both source operands. It registers op_1, op_2 and the 3-bit result-select into an ID/EX pipeline register with a valid/ready handshake.

Parameters:
DW, 12, data width of operands and registers
NREG, 8, number of architectural registers
AW, 3, register address width (log2 NREG)
CNTW, 16, width of issued-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
instr  in  12  [11:9] opcode/select, [8:6] rd, [5:3] rs1, [2:0] rs2
instr_valid  in  1  instr is valid
instr_ready  out  1  stage can accept instr this cycle
flush  in  1  kill ID/EX contents and drop the current instr
wb_en  in  1  write-back enable
wb_addr  in  AW  write-back register index
wb_data  in  DW  write-back data
ex_valid  out  1  ID/EX register holds a valid op
ex_ready  in  1  execute stage accepts the op
ex_op_1  out  DW  operand 1 to execute
ex_op_2  out  DW  operand 2 to execute
ex_sel  out  3  result-mux select (= opcode)
ex_rd  out  AW  destination register carried to write-back
issue_cnt  out  CNTW  count of ops accepted into ID/EX

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - all registers R0..R7, ex_op_1, ex_op_2, ex_sel, ex_rd and issue_cnt are cleared to 0;
  - ex_valid is cleared to 0.
  - instr_ready is combinational. It is 1 during reset only because ex_valid=0; nothing is accepted while rst_n=0.
- Reset mid-operation discards any held op and ignores any write-back in that cycle.
- Handshake:
  - instr_ready = !ex_valid || ex_ready.
  - An instr is accepted when instr_valid && instr_ready && !flush.
  - On accept: ID/EX loads the decoded op, ex_valid becomes 1, and issue_cnt increments, wrapping from 2^CNTW-1 to 0.
  - If ex_valid && ex_ready and there is no accept, ex_valid goes to 0 and the data fields hold.
  - If ex_valid && !ex_ready, all ex_* outputs hold stable.
- Latency: 1 cycle from accept to ex_valid.
- flush=1 forces ex_valid to 0 next cycle, blocks acceptance, and leaves issue_cnt unchanged. Flush has priority over accept and stall.
- Register file:
  - A write occurs at the clk edge when wb_en=1 and wb_addr!=0.
  - R0 always reads 0; writes to it are ignored.
  - Write-back is independent of stall and flush.
- Operand read is combinational from rs1/rs2 in the accept cycle. Same-cycle write/read behaviour depends on the optional feature below.
- No arithmetic in this stage. Opcode passes unmodified to ex_sel; opcode 0 selects the zero-result unit.

Optional Feature:
OPF_WB_BYPASS_EN
- Defined: if wb_en && wb_addr==rsN && rsN!=0 in the accept cycle, operand N takes wb_data (write-through bypass).
- Undefined: operand N takes the pre-write register value. Software or hazard logic must insert a bubble.

Decomposition:
- Package opf_pkg holds:
  - DW, AW and NREG constants;
  - opcode field bit positions;
  - an instr_t packed struct {op, rd, rs1, rs2};
  - opcode localparams OP_ZERO=3'd0 … OP_7=3'd7.
- One natural sub-module: opf_regfile, the 8×12 register file with 2 read ports, 1 write port, R0 hardwired to zero and the optional bypass.

Test Plan:
- Reset then writes:
  - Hold rst_n=0 for 2 cycles → ex_valid=0, issue_cnt=0.
  - Write R3=0x0A5 and R5=0x7FF via wb.
  - Issue instr {op=2, rd=1, rs1=3, rs2=5} → next cycle ex_op_1=0x0A5, ex_op_2=0x7FF, ex_sel=2, ex_rd=1, issue_cnt=1.
- Stall:
  - With ex_ready=0, issue 2 instrs back-to-back.
  - → instr_ready=0 after the first; ex_* hold for 3 cycles.
  - Raise ex_ready → second op appears next cycle, issue_cnt=2.
- R0:
  - wb_en=1, wb_addr=0, wb_data=0xFFF, then read rs1=0 → ex_op_1=0x000.
- Same-cycle write/read: wb R4=0x123 in the same cycle as accepting rs2=4, with R4 previously 0x456.
  - With OPF_WB_BYPASS_EN → ex_op_2=0x123.
  - Without it → 0x456.
- Flush:
  - Assert flush together with instr_valid while ex_valid=1 → ex_valid=0 next cycle, issue_cnt unchanged.
  - A write-back in that same cycle still lands.
- Counter wrap and mid-stream reset:
  - Preload via 65535 accepts; one more accept → issue_cnt=0.
  - Assert rst_n=0 with ex_valid=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/opf_pkg.sv
// opf_pkg: shared constants and types for the operand-fetch stage.
//   DW/AW/NREG   operand width, register index width, register count
//   OP_*_POS     instruction field bit positions
//   instr_t      decoded view of a 12-bit instruction {op, rd, rs1, rs2}
//   OP_ZERO..OP_7 result-mux select codes carried unmodified to execute
package opf_pkg;

    localparam int unsigned DW   = 12;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    localparam int unsigned OP_MSB  = 11;
    localparam int unsigned OP_LSB  = 9;
    localparam int unsigned RD_MSB  = 8;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned RS1_MSB = 5;
    localparam int unsigned RS1_LSB = 3;
    localparam int unsigned RS2_MSB = 2;
    localparam int unsigned RS2_LSB = 0;

    typedef struct packed {
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
    } instr_t;

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_1    = 3'd1;
    localparam logic [2:0] OP_2    = 3'd2;
    localparam logic [2:0] OP_3    = 3'd3;
    localparam logic [2:0] OP_4    = 3'd4;
    localparam logic [2:0] OP_5    = 3'd5;
    localparam logic [2:0] OP_6    = 3'd6;
    localparam logic [2:0] OP_7    = 3'd7;

endpackage

// File: rtl/opf_regfile.sv
// opf_regfile: NREG x DW register file, two combinational read ports, one write port.
//   clk_i, rst_ni          clock, synchronous active-low reset (clears every register)
//   we_i/waddr_i/wdata_i   write port; writes to index 0 are dropped
//   raddr_a_i/rdata_a_o    read port A
//   raddr_b_i/rdata_b_o    read port B
// Index 0 always reads zero.
// Build option OPF_WB_BYPASS_EN: a read of the register being written this cycle returns the
// write data; otherwise it returns the pre-write contents.
module opf_regfile
    import opf_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef OPF_WB_BYPASS_EN
        if (we_i && (waddr_i == raddr_a_i) && (raddr_a_i != '0)) rdata_a_o = wdata_i;
        if (we_i && (waddr_i == raddr_b_i) && (raddr_b_i != '0)) rdata_b_o = wdata_i;
`endif
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode + operand fetch feeding the ID/EX pipeline register.
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   instr_i/instr_valid_i/instr_ready_o  instruction in: [11:9] op, [8:6] rd, [5:3] rs1, [2:0] rs2
//   flush_i                          drop ID/EX contents and the current instruction
//   wb_en_i/wb_addr_i/wb_data_i      register write-back port
//   ex_valid_o/ex_ready_i            ID/EX handshake towards execute
//   ex_op_1_o, ex_op_2_o             fetched source operands
//   ex_sel_o                         result-mux select (opcode, unmodified)
//   ex_rd_o                          destination index carried to write-back
//   issue_cnt_o                      wrapping count of instructions accepted into ID/EX
// Build option OPF_WB_BYPASS_EN (in opf_regfile): same-cycle write-back forwards to operands.
module operand_fetch_stage
    import opf_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [DW-1:0]   instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [DW-1:0]   wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [DW-1:0]   ex_op_1_o,
    output logic [DW-1:0]   ex_op_2_o,
    output logic [2:0]      ex_sel_o,
    output logic [AW-1:0]   ex_rd_o,
    output logic [CNTW-1:0] issue_cnt_o
);

    instr_t        instr;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          accept;

    logic            ex_valid_q, ex_valid_d;
    logic [DW-1:0]   ex_op_1_q, ex_op_1_d;
    logic [DW-1:0]   ex_op_2_q, ex_op_2_d;
    logic [2:0]      ex_sel_q, ex_sel_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic [CNTW-1:0] issue_cnt_q, issue_cnt_d;

    assign instr = instr_t'(instr_i);

    opf_regfile u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (instr.rs1),
        .raddr_b_i (instr.rs2),
        .rdata_a_o (rs1_data),
        .rdata_b_o (rs2_data)
    );

    assign instr_ready_o = !ex_valid_q || ex_ready_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_op_1_d   = ex_op_1_q;
        ex_op_2_d   = ex_op_2_q;
        ex_sel_d    = ex_sel_q;
        ex_rd_d     = ex_rd_q;
        issue_cnt_d = issue_cnt_q;
        if (flush_i) begin
            // Data fields hold; only the valid bit is killed.
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d  = 1'b1;
            ex_op_1_d   = rs1_data;
            ex_op_2_d   = rs2_data;
            ex_sel_d    = instr.op;
            ex_rd_d     = instr.rd;
            issue_cnt_d = issue_cnt_q + CNTW'(1);
        end else if (ex_valid_q && ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_valid_q  <= 1'b0;
            ex_op_1_q   <= '0;
            ex_op_2_q   <= '0;
            ex_sel_q    <= OP_ZERO;
            ex_rd_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_1_q   <= ex_op_1_d;
            ex_op_2_q   <= ex_op_2_d;
            ex_sel_q    <= ex_sel_d;
            ex_rd_q     <= ex_rd_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign ex_op_1_o   = ex_op_1_q;
    assign ex_op_2_o   = ex_op_2_q;
    assign ex_sel_o    = ex_sel_q;
    assign ex_rd_o     = ex_rd_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed stimulus with a scoreboard of expected ID/EX contents.
module tb_operand_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [11:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [11:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [11:0] ex_op_1;
    logic [11:0] ex_op_2;
    logic [2:0]  ex_sel;
    logic [2:0]  ex_rd;
    logic [15:0] issue_cnt;

    operand_fetch_stage #(.CNTW(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .flush_i       (flush),
        .wb_en_i       (wb_en),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .ex_valid_o    (ex_valid),
        .ex_ready_i    (ex_ready),
        .ex_op_1_o     (ex_op_1),
        .ex_op_2_o     (ex_op_2),
        .ex_sel_o      (ex_sel),
        .ex_rd_o       (ex_rd),
        .issue_cnt_o   (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] op1;
        logic [11:0] op2;
        logic [2:0]  sel;
        logic [2:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_rf[8];
    logic [15:0] m_cnt;
    int          n_vec;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rd_model(input logic [2:0] a);
        if (a == 3'd0) return 12'h000;
`ifdef OPF_WB_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [11:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0]};
    endfunction

    // One clock: predict from the driven inputs, clock, then check against the scoreboard.
    task automatic tick();
        exp_t e;
        logic rdy;
        logic acc;
        #1;
        rdy = (exp_q.size() == 0) || ex_ready;
        chk("instr_ready", 32'(instr_ready), 32'(rdy));
        acc = rst_n && instr_valid && rdy && !flush;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
        end else begin
            if (exp_q.size() != 0 && (ex_ready || flush)) void'(exp_q.pop_front());
            if (acc) begin
                e.op1 = rd_model(instr[5:3]);
                e.op2 = rd_model(instr[2:0]);
                e.sel = instr[11:9];
                e.rd  = instr[8:6];
                exp_q.push_back(e);
                m_cnt = m_cnt + 16'd1;
            end
            if (wb_en && wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(exp_q.size() != 0));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        if (exp_q.size() != 0) begin
            chk("ex_op_1", 32'(ex_op_1), 32'(exp_q[0].op1));
            chk("ex_op_2", 32'(ex_op_2), 32'(exp_q[0].op2));
            chk("ex_sel", 32'(ex_sel), 32'(exp_q[0].sel));
            chk("ex_rd", 32'(ex_rd), 32'(exp_q[0].rd));
        end
    endtask

    initial begin
        logic [15:0] cnt_save;
        n_vec = 0;
        n_fail = 0;
        m_cnt = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;

        // Reset
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_ex_op_1", 32'(ex_op_1), 32'd0);
        chk("rst_ex_sel", 32'(ex_sel), 32'd0);
        rst_n = 1'b1;

        // Write R3, R5 then read them
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 12'h0A5; tick();
        wb_addr = 3'd5; wb_data = 12'h7FF; tick();
        wb_en = 1'b0;
        instr = mk(2, 1, 3, 5); instr_valid = 1'b1; tick();
        instr_valid = 1'b0;
        chk("basic_op_1", 32'(ex_op_1), 32'h0A5);
        chk("basic_op_2", 32'(ex_op_2), 32'h7FF);
        chk("basic_sel", 32'(ex_sel), 32'd2);
        chk("basic_rd", 32'(ex_rd), 32'd1);
        chk("basic_cnt", 32'(issue_cnt), 32'd1);
        tick();

        // Stall with two back-to-back instructions
        ex_ready = 1'b0;
        instr = mk(3, 2, 5, 3); instr_valid = 1'b1; tick();
        instr = mk(4, 6, 0, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(instr_ready), 32'd0);
            chk("stall_op_1", 32'(ex_op_1), 32'h7FF);
            chk("stall_op_2", 32'(ex_op_2), 32'h0A5);
            chk("stall_sel", 32'(ex_sel), 32'd3);
        end
        ex_ready = 1'b1; tick();
        instr_valid = 1'b0;
        chk("stall2_op_1", 32'(ex_op_1), 32'h000);
        chk("stall2_op_2", 32'(ex_op_2), 32'h7FF);
        chk("stall2_sel", 32'(ex_sel), 32'd4);
        chk("stall2_cnt", 32'(issue_cnt), 32'd3);
        tick();

        // R0 writes are dropped
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 12'hFFF; tick();
        wb_en = 1'b0;
        instr = mk(1, 7, 0, 0); instr_valid = 1'b1; tick();
        instr_valid = 1'b0;
        chk("r0_op_1", 32'(ex_op_1), 32'h000);
        tick();

        // Same-cycle write/read
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 12'h456; tick();
        wb_data = 12'h123; instr = mk(5, 2, 1, 4); instr_valid = 1'b1; tick();
        wb_en = 1'b0; instr_valid = 1'b0;
`ifdef OPF_WB_BYPASS_EN
        chk("bypass_op_2", 32'(ex_op_2), 32'h123);
`else
        chk("bypass_op_2", 32'(ex_op_2), 32'h456);
`endif
        tick();

        // Flush while holding a valid op; write-back still lands
        instr = mk(6, 3, 3, 3); instr_valid = 1'b1; tick();
        cnt_save = issue_cnt;
        chk("pre_flush_valid", 32'(ex_valid), 32'd1);
        flush = 1'b1; instr = mk(7, 1, 2, 2);
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 12'h321; tick();
        flush = 1'b0; instr_valid = 1'b0; wb_en = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_cnt", 32'(issue_cnt), 32'(cnt_save));
        instr = mk(1, 0, 6, 6); instr_valid = 1'b1; tick();
        instr_valid = 1'b0;
        chk("flush_wb_op_1", 32'(ex_op_1), 32'h321);
        tick();

        // Counter wrap
        instr = mk(1, 1, 1, 1); instr_valid = 1'b1;
        while (m_cnt != 16'hFFFF) tick();
        chk("pre_wrap_cnt", 32'(issue_cnt), 32'hFFFF);
        tick();
        chk("wrap_cnt", 32'(issue_cnt), 32'd0);

        // Mid-stream reset with a held op and a write-back in flight
        ex_ready = 1'b0; rst_n = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 12'hABC; tick();
        chk("mrst_valid", 32'(ex_valid), 32'd0);
        chk("mrst_op_1", 32'(ex_op_1), 32'd0);
        chk("mrst_op_2", 32'(ex_op_2), 32'd0);
        chk("mrst_sel", 32'(ex_sel), 32'd0);
        chk("mrst_rd", 32'(ex_rd), 32'd0);
        chk("mrst_cnt", 32'(issue_cnt), 32'd0);
        rst_n = 1'b1; wb_en = 1'b0; instr_valid = 1'b0; ex_ready = 1'b1; tick();
        instr = mk(3, 4, 2, 3); instr_valid = 1'b1; tick();
        instr_valid = 1'b0;
        chk("post_rst_r2", 32'(ex_op_1), 32'h000);
        chk("post_rst_r3", 32'(ex_op_2), 32'h000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
